jtag_debug_cmd_sysclk: RTL and testbench
========================================

Name: jtag_debug_cmd_sysclk

Overview:
- System-clock half of the debug-module JTAG bridge, parametrised in IR width (channel count), data width and synchroniser depth.
- Synchronises the virtual-JTAG update-DR/update-IR strobes from the tck domain and captures the shift register into jdo.
- Decodes the latched IR into a one-hot, valid/ready command handshake per channel, replacing fixed single-cycle take_action strobes.
- Adds overrun counting, IR-update abort and post-reset spurious-strobe suppression.

Parameters:
- IR_W, 2, IR width; NUM_CH = 2**IR_W command channels.
- DATA_W, 38, width of sr/jdo.
- ACT_BIT, 35, bit of captured sr giving action (1) vs no-action (0); must be < DATA_W.
- SYNC_STAGES, 2, synchroniser flops per strobe; legal values >= 2.
- OVR_W, 8, overrun counter width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vs_udr  in  1  update-DR level from tck domain (asynchronous)
- vs_uir  in  1  update-IR level from tck domain (asynchronous)
- ir_in  in  IR_W  virtual IR; quasi-static, stable across every udr strobe by protocol
- sr  in  DATA_W  tck-domain shift register; stable while vs_udr high
- cmd_ready  in  NUM_CH  per-channel consumer accept
- overrun_clr  in  1  synchronous clear of overrun_cnt
- jdo  out  DATA_W  captured command data
- ir_latched  out  IR_W  channel of the current/last command
- cmd_valid  out  NUM_CH  one-hot or zero: command pending on channel
- cmd_act  out  1  captured sr[ACT_BIT] for the pending command
- uir_pulse  out  1  one-cycle pulse per synchronised update-IR
- overrun_cnt  out  OVR_W  saturating count of dropped commands

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, edge registers, jdo, ir_latched, cmd_valid, cmd_act, uir_pulse, overrun_cnt = 0; armed_udr = armed_uir = 0.
- Synchroniser: per strobe, s[0] <= input, s[i] <= s[i-1]; prev <= s[N-1], where N = SYNC_STAGES. Raw edge = s[N-1] & ~prev.
- Arming: armed_x sets on the first cycle s[N-1] == 0 after reset. An edge counts only if armed_x was already 1, so a strobe held high through reset release produces no pulse.
- Latency: vs_udr rising before clk edge 1 → outputs updated after edge N+1 (edge 3 for N=2). uir_pulse has the same latency and is high for exactly 1 cycle.
- On udr_pulse, in the same edge:
  - jdo <= sr; ir_latched <= ir_in; cmd_act <= sr[ACT_BIT]; cmd_valid <= onehot(ir_in).
- Accept: cmd_valid[c] & cmd_ready[c] at an edge clears cmd_valid[c] (unless a new udr_pulse loads it). cmd_ready is ignored on non-valid channels.
- Overrun: udr_pulse while cmd_valid != 0 and the pending channel is not accepted that same edge. The new command replaces the old one, and overrun_cnt increments, saturating at 2**OVR_W-1. No overrun when accept and udr_pulse coincide.
- uir_pulse clears cmd_valid (abort, not an overrun); jdo/cmd_act/ir_latched are held. If udr_pulse and uir_pulse coincide, udr wins: the command is loaded and uir_pulse is still output.
- overrun_clr: overrun_cnt <= 0. If it coincides with an overrun increment, result = 1.
- Reset mid-command: pending command lost, counter cleared; rearm rules apply.
- No combinational path from inputs to outputs.

Test Plan:
- vs_udr 0→1 with ir_in=2, sr=38'h08_0000_1234, cmd_ready=0, N=2 → after edge 3:
  - cmd_valid=4'b0100, jdo=38'h08_0000_1234, cmd_act=1, ir_latched=2;
  - cmd_ready[2]=1 for 1 cycle → cmd_valid=0, overrun_cnt=0.
- Two udr strobes (ch1 then ch3), no ready → cmd_valid=4'b1000, jdo = second sr, overrun_cnt=1. Repeat 300 times with OVR_W=8 → counter holds 255; overrun_clr → 0. Clear coincident with an overrun → 1.
- cmd_ready[1] asserted in the same edge as a new udr_pulse for ch1 → cmd_valid stays 4'b0010 with new data, overrun_cnt unchanged.
- Pending ch0 command, vs_uir toggles → uir_pulse high for 1 cycle, cmd_valid=0, jdo unchanged, overrun_cnt unchanged.
- vs_udr held high across reset release → no cmd_valid. Then low for ≥3 cycles and high again → exactly one command.
- Assert reset_n=0 asynchronously mid-cycle with a command pending → all outputs 0 immediately, without waiting for a clk edge. Repeat the first scenario with SYNC_STAGES=3 → response after edge 4.

Source files
------------

// File: rtl/jtag_debug_cmd_sysclk.sv
// System-clock half of the debug JTAG bridge: synchronises the tck-domain update
// strobes, captures the shift register and presents it as a per-channel valid/ready command.
module jtag_debug_cmd_sysclk #(
  parameter int IR_W        = 2,
  parameter int DATA_W      = 38,
  parameter int ACT_BIT     = 35,
  parameter int SYNC_STAGES = 2,
  parameter int OVR_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [DATA_W-1:0]      sr,
  input  logic [(1<<IR_W)-1:0]   cmd_ready,
  input  logic                   overrun_clr,
  output logic [DATA_W-1:0]      jdo,
  output logic [IR_W-1:0]        ir_latched,
  output logic [(1<<IR_W)-1:0]   cmd_valid,
  output logic                   cmd_act,
  output logic                   uir_pulse,
  output logic [OVR_W-1:0]       overrun_cnt
);

  localparam int NUM_CH = 1 << IR_W;

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   udr_prev;
  logic                   uir_prev;
  logic                   udr_armed;
  logic                   uir_armed;

  logic                   udr_pulse;
  logic                   uir_hit;
  logic                   accept;
  logic                   overrun;
  logic [NUM_CH-1:0]      onehot;

  // fill marks when the synchroniser output holds a real sample rather than the
  // reset zero, so a strobe held high through reset release never arms its edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync  <= '0;
      uir_sync  <= '0;
      fill      <= '0;
      udr_prev  <= 1'b0;
      uir_prev  <= 1'b0;
      udr_armed <= 1'b0;
      uir_armed <= 1'b0;
    end else begin
      udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      udr_prev  <= udr_sync[SYNC_STAGES-1];
      uir_prev  <= uir_sync[SYNC_STAGES-1];
      udr_armed <= udr_armed | (fill[SYNC_STAGES-1] & ~udr_sync[SYNC_STAGES-1]);
      uir_armed <= uir_armed | (fill[SYNC_STAGES-1] & ~uir_sync[SYNC_STAGES-1]);
    end
  end

  always_comb begin
    udr_pulse = udr_sync[SYNC_STAGES-1] & ~udr_prev & udr_armed;
    uir_hit   = uir_sync[SYNC_STAGES-1] & ~uir_prev & uir_armed;
    onehot    = NUM_CH'(1) << ir_in;
    accept    = |(cmd_valid & cmd_ready);
    overrun   = udr_pulse & (|cmd_valid) & ~accept;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo        <= '0;
      ir_latched <= '0;
      cmd_valid  <= '0;
      cmd_act    <= 1'b0;
      uir_pulse  <= 1'b0;
    end else begin
      uir_pulse <= uir_hit;
      if (udr_pulse) begin
        jdo        <= sr;
        ir_latched <= ir_in;
        cmd_act    <= sr[ACT_BIT];
        cmd_valid  <= onehot;
      end else if (uir_hit) begin
        cmd_valid  <= '0;
      end else begin
        cmd_valid  <= cmd_valid & ~cmd_ready;
      end
    end
  end

  // a clear that coincides with a new overrun keeps that one overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= '0;
    end else if (overrun_clr) begin
      overrun_cnt <= overrun ? OVR_W'(1) : '0;
    end else if (overrun && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + OVR_W'(1);
    end
  end

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk.sv
// Scoreboard bench for jtag_debug_cmd_sysclk: stimulus schedules strobes, a command-level
// model pushes expected outputs, and a negedge monitor pops and compares them.
module tb_jtag_debug_cmd_sysclk;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_udr, vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [3:0]  cmd_ready;
  logic        overrun_clr;
  logic [37:0] jdo;
  logic [1:0]  ir_latched;
  logic [3:0]  cmd_valid;
  logic        cmd_act;
  logic        uir_pulse;
  logic [7:0]  overrun_cnt;

  logic [37:0] d3_jdo;
  logic [1:0]  d3_ir_latched;
  logic [3:0]  d3_cmd_valid;
  logic        d3_cmd_act;
  logic        d3_uir_pulse;
  logic [7:0]  d3_overrun_cnt;

  always #5 clk = ~clk;

  jtag_debug_cmd_sysclk #(.IR_W(2), .DATA_W(38), .ACT_BIT(35), .SYNC_STAGES(2), .OVR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_ready(cmd_ready), .overrun_clr(overrun_clr), .jdo(jdo), .ir_latched(ir_latched),
    .cmd_valid(cmd_valid), .cmd_act(cmd_act), .uir_pulse(uir_pulse), .overrun_cnt(overrun_cnt));

  jtag_debug_cmd_sysclk #(.IR_W(2), .DATA_W(38), .ACT_BIT(35), .SYNC_STAGES(3), .OVR_W(8)) dut3 (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_ready(cmd_ready), .overrun_clr(overrun_clr), .jdo(d3_jdo), .ir_latched(d3_ir_latched),
    .cmd_valid(d3_cmd_valid), .cmd_act(d3_cmd_act), .uir_pulse(d3_uir_pulse),
    .overrun_cnt(d3_overrun_cnt));

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] d;
  } ev_t;

  typedef struct {
    int          e;
    logic [3:0]  cv;
    logic [37:0] jdo;
    logic [1:0]  ir;
    logic        act;
    logic        uir;
    logic [7:0]  cnt;
  } exp_t;

  ev_t  udr_ev[int];
  bit   uir_ev[int];
  exp_t q[$];
  exp_t held;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Command-level reference model: one pending slot, a saturating drop counter.
  initial begin : model
    logic        pend, do_udr, do_uir, acc, ovr;
    logic [1:0]  ch;
    logic [37:0] data;
    logic        act;
    logic [7:0]  cnt;
    ev_t         e;
    pend = 0; ch = 0; data = 0; act = 0; cnt = 0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (!reset_n) begin
        pend = 0; ch = 0; data = 0; act = 0; cnt = 0;
      end else begin
        do_udr = udr_ev.exists(edge_n);
        do_uir = uir_ev.exists(edge_n);
        acc    = pend && cmd_ready[ch];
        ovr    = do_udr && pend && !acc;
        if (overrun_clr) cnt = ovr ? 8'd1 : 8'd0;
        else if (ovr && cnt != 8'hFF) cnt = cnt + 8'd1;
        if (do_udr) begin
          e = udr_ev[edge_n];
          udr_ev.delete(edge_n);
          pend = 1; ch = e.ir; data = e.d; act = e.d[35];
        end else if (do_uir || acc) begin
          pend = 0;
        end
        if (do_uir) uir_ev.delete(edge_n);
        if (do_udr || do_uir || overrun_clr || cmd_ready != 4'b0)
          q.push_back('{edge_n, pend ? (4'b0001 << ch) : 4'b0000, data, ch, act, do_uir, cnt});
      end
    end
  end

  initial begin : monitor
    exp_t x;
    held = '{0, 4'b0, 38'b0, 2'b0, 1'b0, 1'b0, 8'b0};
    forever begin
      @(negedge clk);
      if (reset_n) begin
        while (q.size() != 0 && q[0].e < edge_n) begin
          x = q.pop_front();
          chk("stale_expectation", 64'(x.e), 64'(edge_n));
        end
        if (q.size() != 0 && q[0].e == edge_n) begin
          x = q.pop_front();
          chk("cmd_valid", 64'(cmd_valid), 64'(x.cv));
          chk("jdo", 64'(jdo), 64'(x.jdo));
          chk("ir_latched", 64'(ir_latched), 64'(x.ir));
          chk("cmd_act", 64'(cmd_act), 64'(x.act));
          chk("uir_pulse", 64'(uir_pulse), 64'(x.uir));
          chk("overrun_cnt", 64'(overrun_cnt), 64'(x.cnt));
          held = x;
          held.uir = 1'b0;
        end else begin
          chk("idle_cmd_valid", 64'(cmd_valid), 64'(held.cv));
          chk("idle_uir_pulse", 64'(uir_pulse), 64'(1'b0));
        end
      end
    end
  end

  // Effect of a strobe raised after edge k is visible after edge k+1+N.
  task automatic strobe(input bit u, input bit i, input logic [1:0] ir, input logic [37:0] d,
                        input logic [3:0] mask, input bit clr);
    @(negedge clk);
    if (u) begin
      ir_in  = ir;
      sr     = d;
      vs_udr = 1'b1;
      udr_ev[edge_n + 1 + N] = '{ir, d};
    end
    if (i) begin
      vs_uir = 1'b1;
      uir_ev[edge_n + 1 + N] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = mask; overrun_clr = clr;
    @(negedge clk);
    cmd_ready = 4'b0; overrun_clr = 1'b0;
  endtask

  task automatic idle(input logic [3:0] mask, input bit clr);
    @(negedge clk);
    cmd_ready = mask; overrun_clr = clr;
    @(negedge clk);
    cmd_ready = 4'b0; overrun_clr = 1'b0;
  endtask

  task automatic reset_async();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    chk("rst_jdo", 64'(jdo), 64'(0));
    chk("rst_ir_latched", 64'(ir_latched), 64'(0));
    chk("rst_cmd_act", 64'(cmd_act), 64'(0));
    chk("rst_uir_pulse", 64'(uir_pulse), 64'(0));
    chk("rst_overrun_cnt", 64'(overrun_cnt), 64'(0));
    udr_ev.delete();
    uir_ev.delete();
    q.delete();
    held = '{0, 4'b0, 38'b0, 2'b0, 1'b0, 1'b0, 8'b0};
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    logic [37:0] d;
    logic [3:0]  m;
    int          op;
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = 2'd0; sr = '0;
    cmd_ready = 4'b0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_cmd_valid", 64'(cmd_valid), 64'(0));
    chk("init_jdo", 64'(jdo), 64'(0));
    chk("init_overrun_cnt", 64'(overrun_cnt), 64'(0));
    chk("init_d3_cmd_valid", 64'(d3_cmd_valid), 64'(0));
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // first command; the 3-stage instance answers one edge later
    fork
      strobe(1, 0, 2'd2, 38'h08_0000_1234, 4'b0, 0);
      begin
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("sync3_not_yet", 64'(d3_cmd_valid), 64'(0));
        @(negedge clk);
        chk("sync3_cmd_valid", 64'(d3_cmd_valid), 64'(4'b0100));
        chk("sync3_jdo", 64'(d3_jdo), 64'(38'h08_0000_1234));
      end
    join
    idle(4'b0100, 0);

    strobe(1, 0, 2'd1, 38'h00_1111_0001, 4'b0, 0);
    strobe(1, 0, 2'd3, 38'h3F_2222_0002, 4'b0, 0);

    for (int i = 0; i < 300; i++)
      strobe(1, 0, 2'(i), 38'({$urandom(), $urandom()}), 4'b0, 0);
    idle(4'b0, 1);
    strobe(1, 0, 2'd0, 38'h01_0000_0003, 4'b0, 1);

    strobe(1, 0, 2'd1, 38'h02_0000_0004, 4'b0, 0);
    strobe(1, 0, 2'd1, 38'h0A_5555_0005, 4'b0010, 0);

    strobe(1, 0, 2'd0, 38'h08_6666_0006, 4'b0, 0);
    strobe(0, 1, 2'd0, 38'h0, 4'b0, 0);
    strobe(1, 1, 2'd3, 38'h15_7777_0007, 4'b0, 0);

    strobe(1, 0, 2'd2, 38'h2A_8888_0008, 4'b0, 0);
    reset_async();
    repeat (4) @(negedge clk);

    @(negedge clk);
    vs_udr = 1'b1;
    reset_async();
    repeat (6) @(negedge clk);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    strobe(1, 0, 2'd1, 38'h11_9999_0009, 4'b0, 0);
    idle(4'b0, 0);

    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      d  = 38'({$urandom(), $urandom()});
      m  = 4'($urandom()) & (($urandom_range(0, 2) == 0) ? 4'hF : 4'h0);
      if (op <= 4)      strobe(1, 0, 2'($urandom()), d, m, $urandom_range(0, 7) == 0);
      else if (op == 5) strobe(0, 1, 2'd0, d, m, 0);
      else if (op == 6) strobe(1, 1, 2'($urandom()), d, m, 0);
      else              idle(m, $urandom_range(0, 7) == 0);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
